// File: rtl/lockout_if.sv
// Handshake bundle between the confirm front-end, the lockout controller and the door FSM.
// The controller takes the slave view; the driver of attempts and verdicts takes the master view.
interface lockout_if;
   logic       i_attempt;
   logic       i_correct;
   logic       i_incorrect;
   logic       i_relock;
   logic       o_confirm;
   logic       o_locked;
   logic       o_open;
   logic       o_rejected;
   logic [7:0] o_secs_left;
   logic [1:0] o_trials_left;
   logic [1:0] o_state;

   modport master (
      output i_attempt, i_correct, i_incorrect, i_relock,
      input  o_confirm, o_locked, o_open, o_rejected, o_secs_left, o_trials_left, o_state
   );

   modport slave (
      input  i_attempt, i_correct, i_incorrect, i_relock,
      output o_confirm, o_locked, o_open, o_rejected, o_secs_left, o_trials_left, o_state
   );
endinterface

// File: rtl/lockout_controller.sv
// Attempt sequencer with failure counting and an escalating, tick-timed lockout.
// Every output is a flop; level outputs are loaded from the next-state values.
module lockout_controller #(
   parameter int unsigned CLK_IN         = 50_000_000,
   parameter int unsigned TICK_DIV       = CLK_IN,
   parameter int unsigned MAX_TRIALS     = 3,
   parameter int unsigned BASE_LOCK_S    = 10,
   parameter int unsigned MAX_LOCK_S     = 160,
   parameter int unsigned RESULT_TIMEOUT = 16
) (
   input logic      i_clk,
   input logic      i_reset,
   lockout_if.slave bus
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WaitW = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
   localparam logic [TickW-1:0] TickMax   = TickW'(TICK_DIV - 1);
   localparam logic [WaitW-1:0] WaitMax   = WaitW'(RESULT_TIMEOUT - 1);
   localparam logic [7:0]       BaseLock  = 8'(BASE_LOCK_S);
   localparam logic [8:0]       MaxLock9  = 9'(MAX_LOCK_S);
   localparam logic [1:0]       MaxTrials = 2'(MAX_TRIALS);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWait   = 2'd1,
      StLocked = 2'd2,
      StOpen   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       fail_cnt_q, fail_cnt_d;
   logic [7:0]       cur_lock_q, cur_lock_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic [7:0]       secs_left_q, secs_left_d;
   logic [1:0]       trials_left_q, trials_left_d;
   logic             confirm_q, confirm_d;
   logic             rejected_q, rejected_d;
   logic             locked_q, locked_d;
   logic             open_q, open_d;

   logic [8:0] lock_dbl;
   logic [2:0] fail_inc;

   // Doubling is done one bit wider so the cap compare sees the true value.
   assign lock_dbl = {cur_lock_q, 1'b0};
   assign fail_inc = {1'b0, fail_cnt_q} + 3'd1;

   always_comb begin
      state_d     = state_q;
      fail_cnt_d  = fail_cnt_q;
      cur_lock_d  = cur_lock_q;
      tick_cnt_d  = tick_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      secs_left_d = secs_left_q;
      confirm_d   = 1'b0;
      rejected_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.i_attempt) begin
               confirm_d  = 1'b1;
               wait_cnt_d = '0;
               state_d    = StWait;
            end
         end
         StWait: begin
            rejected_d = bus.i_attempt;
            if (bus.i_incorrect) begin
               if (fail_inc == {1'b0, MaxTrials}) begin
                  state_d     = StLocked;
                  secs_left_d = cur_lock_q;
                  tick_cnt_d  = '0;
                  fail_cnt_d  = '0;
                  cur_lock_d  = (lock_dbl > MaxLock9) ? MaxLock9[7:0] : lock_dbl[7:0];
               end else begin
                  fail_cnt_d = fail_inc[1:0];
                  state_d    = StIdle;
               end
            end else if (bus.i_correct) begin
               state_d    = StOpen;
               fail_cnt_d = '0;
               cur_lock_d = BaseLock;
            end else if (wait_cnt_q == WaitMax) begin
               state_d = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StLocked: begin
            rejected_d = bus.i_attempt;
            if (tick_cnt_q == TickMax) begin
               tick_cnt_d  = '0;
               secs_left_d = secs_left_q - 8'd1;
               if (secs_left_q == 8'd1) begin
                  state_d = StIdle;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
         end
         StOpen: begin
            rejected_d = bus.i_attempt;
            if (bus.i_relock) begin
               state_d = StIdle;
            end
         end
      endcase

      trials_left_d = MaxTrials - fail_cnt_d;
      locked_d      = (state_d == StLocked);
      open_d        = (state_d == StOpen);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= StIdle;
         fail_cnt_q    <= '0;
         cur_lock_q    <= BaseLock;
         tick_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         secs_left_q   <= '0;
         trials_left_q <= MaxTrials;
         confirm_q     <= 1'b0;
         rejected_q    <= 1'b0;
         locked_q      <= 1'b0;
         open_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fail_cnt_q    <= fail_cnt_d;
         cur_lock_q    <= cur_lock_d;
         tick_cnt_q    <= tick_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         secs_left_q   <= secs_left_d;
         trials_left_q <= trials_left_d;
         confirm_q     <= confirm_d;
         rejected_q    <= rejected_d;
         locked_q      <= locked_d;
         open_q        <= open_d;
      end
   end

   assign bus.o_state       = state_q;
   assign bus.o_secs_left   = secs_left_q;
   assign bus.o_trials_left = trials_left_q;
   assign bus.o_confirm     = confirm_q;
   assign bus.o_rejected    = rejected_q;
   assign bus.o_locked      = locked_q;
   assign bus.o_open        = open_q;

endmodule

// File: tb/tb_lockout_controller.sv
// Bench for lockout_controller: a vector table, directed escalation/timeout/reset sequences and
// random traffic, every cycle checked against a phase-and-elapsed-time reference model.
module tb_lockout_controller;

   localparam int TD      = 4;
   localparam int MAXT    = 3;
   localparam int BASE    = 10;
   localparam int CAP     = 160;
   localparam int TIMEOUT = 16;

   logic clk;
   logic rst;
   lockout_if bus ();

   lockout_controller #(
      .CLK_IN        (TD),
      .TICK_DIV      (TD),
      .MAX_TRIALS    (MAXT),
      .BASE_LOCK_S   (BASE),
      .MAX_LOCK_S    (CAP),
      .RESULT_TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: phase 0 idle, 1 waiting, 2 locked, 3 open; times are absolute cycle numbers.
   int m_mode, m_fails, m_next, m_len, m_start, m_wstart;
   int e_confirm, e_rej;
   int prev_locked = 0;
   int lock_rise = 0;
   int lock_meas = 0;

   function automatic int exp_secs();
      return (m_mode == 2) ? m_len - (cyc - m_start) / TD : 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fails = 0; m_next = BASE; e_confirm = 0; e_rej = 0;
   endtask

   task automatic model_edge(input int att, input int cor, input int inc, input int rel);
      e_confirm = 0;
      e_rej = 0;
      case (m_mode)
         0: if (att != 0) begin
            e_confirm = 1; m_mode = 1; m_wstart = cyc;
         end
         1: begin
            e_rej = att;
            if (inc != 0) begin
               m_fails++;
               if (m_fails == MAXT) begin
                  m_mode = 2; m_len = m_next; m_start = cyc; m_fails = 0;
                  m_next = (2 * m_next > CAP) ? CAP : 2 * m_next;
               end else begin
                  m_mode = 0;
               end
            end else if (cor != 0) begin
               m_mode = 3; m_fails = 0; m_next = BASE;
            end else if ((cyc - 1) - m_wstart == TIMEOUT - 1) begin
               m_mode = 0;
            end
         end
         2: begin
            e_rej = att;
            if (cyc - m_start == m_len * TD) m_mode = 0;
         end
         default: begin
            e_rej = att;
            if (rel != 0) m_mode = 0;
         end
      endcase
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int att, input int cor, input int inc, input int rel, input int r);
      bus.i_attempt   = att[0];
      bus.i_correct   = cor[0];
      bus.i_incorrect = inc[0];
      bus.i_relock    = rel[0];
      rst             = r[0];
      @(posedge clk);
      #1;
      cyc++;
      if (r != 0) model_reset();
      else model_edge(att, cor, inc, rel);
      bus.i_attempt   = 1'b0;
      bus.i_correct   = 1'b0;
      bus.i_incorrect = 1'b0;
      bus.i_relock    = 1'b0;
      rst             = 1'b0;
      chk("state", int'(bus.o_state), m_mode);
      chk("secs_left", int'(bus.o_secs_left), exp_secs());
      chk("trials_left", int'(bus.o_trials_left), MAXT - m_fails);
      chk("confirm", int'(bus.o_confirm), e_confirm);
      chk("rejected", int'(bus.o_rejected), e_rej);
      chk("locked", int'(bus.o_locked), (m_mode == 2) ? 1 : 0);
      chk("open", int'(bus.o_open), (m_mode == 3) ? 1 : 0);
      if (bus.o_locked && prev_locked == 0) lock_rise = cyc;
      if (!bus.o_locked && prev_locked != 0) lock_meas = cyc - lock_rise;
      prev_locked = int'(bus.o_locked);
   endtask

   task automatic fail_attempt();
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
   endtask

   typedef struct {
      int att, cor, inc, rel;
      int e_state, e_confirm, e_rej, e_locked, e_open, e_secs, e_trials;
   } vec_t;

   vec_t vecs[$];
   int esc[6] = '{10, 20, 40, 80, 160, 160};

   initial begin
      int n;
      int a;
      bus.i_attempt = 1'b0; bus.i_correct = 1'b0; bus.i_incorrect = 1'b0; bus.i_relock = 1'b0;
      rst = 1'b1;
      model_reset();

      //           att cor inc rel  st cf rj lk op secs tr
      vecs.push_back('{1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  3});
      vecs.push_back('{0, 1, 0, 0,  3, 0, 0, 0, 1, 0,  3});
      vecs.push_back('{1, 0, 0, 0,  3, 0, 1, 0, 1, 0,  3});
      vecs.push_back('{0, 0, 0, 0,  3, 0, 0, 0, 1, 0,  3});
      vecs.push_back('{0, 0, 0, 1,  0, 0, 0, 0, 0, 0,  3});
      vecs.push_back('{1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  3});
      vecs.push_back('{1, 0, 0, 0,  1, 0, 1, 0, 0, 0,  3});
      vecs.push_back('{0, 1, 1, 0,  0, 0, 0, 0, 0, 0,  2});
      vecs.push_back('{0, 1, 0, 0,  0, 0, 0, 0, 0, 0,  2});
      vecs.push_back('{0, 0, 0, 1,  0, 0, 0, 0, 0, 0,  2});
      vecs.push_back('{1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  2});
      vecs.push_back('{0, 0, 1, 0,  0, 0, 0, 0, 0, 0,  1});
      vecs.push_back('{1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  1});
      vecs.push_back('{0, 0, 1, 0,  2, 0, 0, 1, 0, 10, 3});
      vecs.push_back('{1, 0, 0, 0,  2, 0, 1, 1, 0, 10, 3});
      vecs.push_back('{0, 0, 0, 0,  2, 0, 0, 1, 0, 10, 3});
      vecs.push_back('{0, 0, 0, 0,  2, 0, 0, 1, 0, 10, 3});
      vecs.push_back('{0, 0, 0, 0,  2, 0, 0, 1, 0, 9,  3});

      step(0, 0, 0, 0, 1);
      foreach (vecs[i]) begin
         step(vecs[i].att, vecs[i].cor, vecs[i].inc, vecs[i].rel, 0);
         chk($sformatf("vec%0d_state", i), int'(bus.o_state), vecs[i].e_state);
         chk($sformatf("vec%0d_confirm", i), int'(bus.o_confirm), vecs[i].e_confirm);
         chk($sformatf("vec%0d_rejected", i), int'(bus.o_rejected), vecs[i].e_rej);
         chk($sformatf("vec%0d_locked", i), int'(bus.o_locked), vecs[i].e_locked);
         chk($sformatf("vec%0d_open", i), int'(bus.o_open), vecs[i].e_open);
         chk($sformatf("vec%0d_secs", i), int'(bus.o_secs_left), vecs[i].e_secs);
         chk($sformatf("vec%0d_trials", i), int'(bus.o_trials_left), vecs[i].e_trials);
      end

      // Escalation 10..160,160 with an attempt landing on each LOCKED->IDLE edge.
      step(0, 0, 0, 0, 1);
      for (int k = 0; k < 6; k++) begin
         for (int f = 0; f < MAXT; f++) fail_attempt();
         chk($sformatf("lock%0d_load", k), int'(bus.o_secs_left), esc[k]);
         n = 0;
         while (m_mode == 2 && n < 2000) begin
            a = (cyc + 1 - m_start == m_len * TD) ? 1 : 0;
            step(a, 0, 0, 0, 0);
            if (a != 0) chk($sformatf("lock%0d_exit_reject", k), int'(bus.o_rejected), 1);
            n++;
         end
         chk($sformatf("lock%0d_unlocked", k), int'(bus.o_locked), 0);
         chk($sformatf("lock%0d_duration", k), lock_meas, esc[k] * TD);
      end
      step(1, 0, 0, 0, 0);
      chk("accept_after_lock", int'(bus.o_confirm), 1);
      step(0, 1, 0, 0, 0);
      chk("open_after_correct", int'(bus.o_open), 1);
      step(0, 0, 0, 1, 0);
      for (int f = 0; f < MAXT; f++) fail_attempt();
      chk("base_after_correct", int'(bus.o_secs_left), BASE);
      while (m_mode == 2) step(0, 0, 0, 0, 0);

      // Verdict timeout keeps the failure count.
      fail_attempt();
      step(1, 0, 0, 0, 0);
      for (int t = 0; t < TIMEOUT - 1; t++) step(0, 0, 0, 0, 0);
      chk("timeout_still_waiting", int'(bus.o_state), 1);
      step(0, 0, 0, 0, 0);
      chk("timeout_idle", int'(bus.o_state), 0);
      chk("timeout_trials", int'(bus.o_trials_left), 2);

      // Reset in the middle of a lockout restores the base length.
      for (int f = 0; f < MAXT - 1; f++) fail_attempt();
      n = 0;
      while (exp_secs() != 7 && n < 2000) begin
         step(0, 0, 0, 0, 0);
         n++;
      end
      chk("mid_lock_secs", int'(bus.o_secs_left), 7);
      step(1, 0, 0, 0, 1);
      chk("rst_state", int'(bus.o_state), 0);
      chk("rst_secs", int'(bus.o_secs_left), 0);
      chk("rst_trials", int'(bus.o_trials_left), MAXT);
      for (int f = 0; f < MAXT; f++) fail_attempt();
      chk("rst_base_lock", int'(bus.o_secs_left), BASE);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         step((($urandom_range(0, 2) == 0) ? 1 : 0), (($urandom_range(0, 4) == 0) ? 1 : 0),
              (($urandom_range(0, 2) == 0) ? 1 : 0), (($urandom_range(0, 5) == 0) ? 1 : 0),
              (($urandom_range(0, 599) == 0) ? 1 : 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lockout_controller.md
# lockout_controller

Sequencing controller between the debounced/edge-detected user confirm and the door lock FSM. Forwards one confirm pulse per attempt, waits for the FSM verdict, and counts consecutive failures. After MAX_TRIALS failures it enforces a timed lockout that doubles on each successive lockout, up to a cap. Seconds-remaining, trials-left and lock status outputs feed the existing 7-segment decoders.

## Interface
- CLK_IN, 50_000_000: input clock frequency in Hz.
- TICK_DIV, CLK_IN: cycles per lockout-countdown tick (one second); set small in simulation.
- MAX_TRIALS, 3: failures that trigger a lockout; range 1..3.
- BASE_LOCK_S, 10: first lockout length in ticks; range 1..255.
- MAX_LOCK_S, 160: lockout length cap in ticks; at least BASE_LOCK_S, at most 255.
- RESULT_TIMEOUT, 16: cycles to wait for a verdict before abandoning the attempt.
- i_clk input 1: clock; all logic on the rising edge.
- i_reset input 1: reset, synchronous and active-high.
- i_attempt input 1: single-cycle attempt request, already edge-detected.
- i_correct input 1: FSM verdict "correct", sampled only in WAIT_RESULT.
- i_incorrect input 1: FSM verdict "incorrect", sampled only in WAIT_RESULT.
- i_relock input 1: single-cycle pulse; leaves OPEN.
- o_confirm output 1: single-cycle confirm pulse to the FSM.
- o_locked output 1: high throughout LOCKED.
- o_open output 1: high throughout OPEN.
- o_rejected output 1: single-cycle pulse when an i_attempt is dropped.
- o_secs_left output 8: remaining lockout ticks; 0 outside LOCKED.
- o_trials_left output 2: MAX_TRIALS minus fail_cnt.
- o_state output 2: IDLE=0, WAIT_RESULT=1, LOCKED=2, OPEN=3.

## Operation
- Internal registers:
  - fail_cnt, 2 bits.
  - cur_lock, 8 bits: next lockout length.
  - tick_cnt, clog2(TICK_DIV) bits.
  - wait_cnt, counts cycles in WAIT_RESULT.
- IDLE:
  - i_attempt: pulse o_confirm, clear wait_cnt, go to WAIT_RESULT.
- WAIT_RESULT:
  - i_incorrect (takes priority if i_correct is also high): fail_cnt+1.
    - If the result equals MAX_TRIALS: go to LOCKED; o_secs_left<=cur_lock; tick_cnt<=0; fail_cnt<=0; cur_lock<=min(2*cur_lock, MAX_LOCK_S), computed in 9 bits then saturated.
    - Otherwise: go to IDLE.
  - i_correct only: go to OPEN; fail_cnt<=0; cur_lock<=BASE_LOCK_S.
  - wait_cnt reaches RESULT_TIMEOUT-1 with no verdict: go to IDLE; fail_cnt unchanged.
  - i_attempt in this state: dropped, o_rejected pulse.
- LOCKED:
  - tick_cnt counts 0..TICK_DIV-1.
  - On wrap, o_secs_left decrements.
  - When the decrement takes o_secs_left from 1 to 0: go to IDLE.
  - i_attempt: dropped, o_rejected pulse.
- OPEN:
  - i_relock: go to IDLE.
  - i_attempt: dropped, o_rejected pulse.
  - fail_cnt stays 0.
- i_relock is ignored outside OPEN. Verdict inputs are ignored outside WAIT_RESULT.
- cur_lock is cleared back to BASE_LOCK_S only by a correct verdict or by reset. Lockouts escalate 10, 20, 40, 80, 160, 160…

## Timing
- Reset values:
  - state IDLE; o_state=0.
  - o_confirm=0, o_locked=0, o_open=0, o_rejected=0.
  - o_secs_left=0; o_trials_left=MAX_TRIALS.
  - fail_cnt=0; cur_lock=BASE_LOCK_S; tick_cnt=0; wait_cnt=0.
- i_reset has priority over every other input, in any state, including mid-lockout and mid-WAIT_RESULT.
- All outputs are registered.
- o_confirm is high in the cycle after i_attempt is sampled high, for exactly one cycle.
- A verdict is accepted at the earliest in the cycle o_confirm is high, i.e. a same-cycle FSM response.
- State and output update one cycle after the verdict is sampled.
- For the first tick of a lockout, the first decrement occurs exactly TICK_DIV cycles after o_locked rises.
- LOCKED lasts exactly N*TICK_DIV cycles for a loaded length N.
- o_rejected is high in the cycle after the dropped i_attempt.
- An i_attempt arriving in the same cycle LOCKED→IDLE or OPEN→IDLE takes effect is rejected; the next i_attempt is accepted.

## Test plan
- Reset, then i_attempt, then i_correct in the o_confirm cycle → one o_confirm pulse; o_open=1; o_state=3; o_trials_left=3. Then i_relock → o_state=0.
- TICK_DIV=4. Three attempts, each answered with i_incorrect → o_trials_left 3→2→1. After the third: o_locked=1, o_secs_left=10, decrementing every 4 cycles. o_locked=0 exactly 40 cycles after rising.
- Second lockout with no correct verdict in between → loads 20. Continue lockouts → 40, 80, 160, 160. Then one correct verdict and three failures → loads 10 again.
- i_attempt during LOCKED, OPEN and WAIT_RESULT → o_rejected pulse, no o_confirm, state unchanged.
- i_correct and i_incorrect high together in WAIT_RESULT → treated as incorrect; fail_cnt increments. No verdict for 16 cycles → back to IDLE; o_trials_left unchanged.
- i_reset asserted with o_secs_left=7 → next cycle o_state=0, o_secs_left=0, o_trials_left=3; the next lockout loads 10.
